// File: rtl/display_pkg.sv
// Shared display constants and drawer state encoding, used by the controller,
// the clearing logic and the box drawer.
package display_pkg;

  localparam int SCREEN_W    = 240;
  localparam int SCREEN_H    = 180;
  localparam int X_BITS      = 8;
  localparam int Y_BITS      = 8;
  localparam int COLOUR_BITS = 3;

  typedef enum logic [1:0] {
    DRAWER_IDLE = 2'd0,
    DRAWER_DRAW = 2'd1,
    DRAWER_DONE = 2'd2
  } drawer_state_e;

  // Counter width for n positions; a single-position counter still needs one bit.
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/box_raster_counter.sv
// Row-major 2-D offset counter for the box raster. Outputs reflect the offset of
// the pixel being emitted this cycle (zero when clear is asserted).
module box_raster_counter
  import display_pkg::*;
#(
  parameter int BOX_W = 16,
  parameter int BOX_H = 8,
  parameter int XW    = cnt_bits(BOX_W),
  parameter int YW    = cnt_bits(BOX_H)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [XW-1:0] x_off,
  output logic [YW-1:0] y_off,
  output logic          last
);

  localparam logic [XW-1:0] X_LAST = XW'(BOX_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(BOX_H - 1);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  // Current offset and next-offset stepping with explicit wrap for any box size.
  always_comb begin
    x_off = clr ? '0 : x_q;
    y_off = clr ? '0 : y_q;
    last  = (x_off == X_LAST) && (y_off == Y_LAST);
    x_d   = x_off;
    y_d   = y_off;
    if (en) begin
      if (x_off == X_LAST) begin
        x_d = '0;
        if (y_off == Y_LAST) begin
          y_d = '0;
        end else begin
          y_d = y_off + YW'(1);
        end
      end else begin
        x_d = x_off + XW'(1);
        y_d = y_off;
      end
    end else begin
      x_d = x_off;
      y_d = y_off;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/box_shape_drawer.sv
// Latches a box origin and colour, then rasterises a filled BOX_W x BOX_H box one
// pixel per clock onto the VGA plot interface, clipping pixels that fall off-screen.
module box_shape_drawer
  import display_pkg::*;
#(
  parameter int SCREEN_W    = display_pkg::SCREEN_W,
  parameter int SCREEN_H    = display_pkg::SCREEN_H,
  parameter int BOX_W       = 16,
  parameter int BOX_H       = 8,
  parameter int X_BITS      = display_pkg::X_BITS,
  parameter int Y_BITS      = display_pkg::Y_BITS,
  parameter int COLOUR_BITS = display_pkg::COLOUR_BITS
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   loadStartAddress,
  input  logic                   startingAddressLoaded,
  input  logic [X_BITS-1:0]      startX,
  input  logic [Y_BITS-1:0]      startY,
  input  logic [COLOUR_BITS-1:0] boxColour,
  output logic [X_BITS-1:0]      vgaX,
  output logic [Y_BITS-1:0]      vgaY,
  output logic [COLOUR_BITS-1:0] vgaColour,
  output logic                   plot,
  output logic                   busy,
  output logic                   shapeDone
);

  localparam int XW = cnt_bits(BOX_W);
  localparam int YW = cnt_bits(BOX_H);

  drawer_state_e          state_q, state_d;
  logic [X_BITS-1:0]      base_x_q, base_x_d;
  logic [Y_BITS-1:0]      base_y_q, base_y_d;
  logic [COLOUR_BITS-1:0] colour_q, colour_d;
  logic [X_BITS-1:0]      vga_x_q, vga_x_d;
  logic [Y_BITS-1:0]      vga_y_q, vga_y_d;
  logic [COLOUR_BITS-1:0] vga_colour_q, vga_colour_d;
  logic                   plot_q, plot_d;
  logic                   busy_q, busy_d;
  logic                   shape_done_q, shape_done_d;

  logic                   start_s, emit_s, last_s;
  logic [XW-1:0]          x_off_s;
  logic [YW-1:0]          y_off_s;
  logic [X_BITS-1:0]      src_x_s;
  logic [Y_BITS-1:0]      src_y_s;
  logic [COLOUR_BITS-1:0] src_colour_s;
  logic [X_BITS:0]        pix_x_s;
  logic [Y_BITS:0]        pix_y_s;

  // The first pixel is emitted on the accepting cycle, so a same-cycle load feeds it directly.
  assign start_s      = (state_q == DRAWER_IDLE) && startingAddressLoaded;
  assign emit_s       = start_s || (state_q == DRAWER_DRAW);
  assign src_x_s      = (start_s && loadStartAddress) ? startX    : base_x_q;
  assign src_y_s      = (start_s && loadStartAddress) ? startY    : base_y_q;
  assign src_colour_s = (start_s && loadStartAddress) ? boxColour : colour_q;
  assign pix_x_s      = {1'b0, src_x_s} + (X_BITS + 1)'(x_off_s);
  assign pix_y_s      = {1'b0, src_y_s} + (Y_BITS + 1)'(y_off_s);

  box_raster_counter #(
    .BOX_W (BOX_W),
    .BOX_H (BOX_H)
  ) u_raster (
    .clock (clock),
    .reset (reset),
    .clr   (start_s),
    .en    (emit_s),
    .x_off (x_off_s),
    .y_off (y_off_s),
    .last  (last_s)
  );

  // Next-state, coordinate latch and next-output computation.
  always_comb begin
    state_d      = state_q;
    base_x_d     = base_x_q;
    base_y_d     = base_y_q;
    colour_d     = colour_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    plot_d       = 1'b0;
    busy_d       = busy_q;
    shape_done_d = 1'b0;
    case (state_q)
      DRAWER_IDLE: begin
        if (loadStartAddress) begin
          base_x_d = startX;
          base_y_d = startY;
          colour_d = boxColour;
        end else begin
          base_x_d = base_x_q;
          base_y_d = base_y_q;
          colour_d = colour_q;
        end
        if (startingAddressLoaded) begin
          busy_d  = 1'b1;
          state_d = last_s ? DRAWER_DONE : DRAWER_DRAW;
        end else begin
          state_d = DRAWER_IDLE;
        end
      end
      DRAWER_DRAW: begin
        state_d = last_s ? DRAWER_DONE : DRAWER_DRAW;
      end
      DRAWER_DONE: begin
        shape_done_d = 1'b1;
        busy_d       = 1'b0;
        state_d      = DRAWER_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = DRAWER_IDLE;
      end
    endcase
    if (emit_s) begin
      vga_x_d      = pix_x_s[X_BITS-1:0];
      vga_y_d      = pix_y_s[Y_BITS-1:0];
      vga_colour_d = src_colour_s;
      plot_d       = (pix_x_s < (X_BITS + 1)'(SCREEN_W)) && (pix_y_s < (Y_BITS + 1)'(SCREEN_H));
    end else begin
      plot_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= DRAWER_IDLE;
      base_x_q     <= '0;
      base_y_q     <= '0;
      colour_q     <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      shape_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_x_q     <= base_x_d;
      base_y_q     <= base_y_d;
      colour_q     <= colour_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      plot_q       <= plot_d;
      busy_q       <= busy_d;
      shape_done_q <= shape_done_d;
    end
  end

  assign vgaX      = vga_x_q;
  assign vgaY      = vga_y_q;
  assign vgaColour = vga_colour_q;
  assign plot      = plot_q;
  assign busy      = busy_q;
  assign shapeDone = shape_done_q;

endmodule

// File: tb/tb_box_shape_drawer.sv
// Directed bench for box_shape_drawer: 16x8 boxes, outputs sampled on the falling edge.
module tb_box_shape_drawer;

  logic       clock = 1'b0;
  logic       reset;
  logic       loadStartAddress;
  logic       startingAddressLoaded;
  logic [7:0] startX;
  logic [7:0] startY;
  logic [2:0] boxColour;
  logic [7:0] vgaX;
  logic [7:0] vgaY;
  logic [2:0] vgaColour;
  logic       plot;
  logic       busy;
  logic       shapeDone;

  int vec_count = 0;
  int err_count = 0;

  always #5 clock = ~clock;

  box_shape_drawer dut (
    .clock                 (clock),
    .reset                 (reset),
    .loadStartAddress      (loadStartAddress),
    .startingAddressLoaded (startingAddressLoaded),
    .startX                (startX),
    .startY                (startY),
    .boxColour             (boxColour),
    .vgaX                  (vgaX),
    .vgaY                  (vgaY),
    .vgaColour             (vgaColour),
    .plot                  (plot),
    .busy                  (busy),
    .shapeDone             (shapeDone)
  );

  // Pulses start (optionally with a load) for one cycle; returns at the negedge showing pixel 0.
  task automatic go(input logic [7:0] x, input logic [7:0] y, input logic [2:0] c, input bit do_load);
    @(negedge clock);
    loadStartAddress      = do_load;
    startingAddressLoaded = 1'b1;
    startX                = x;
    startY                = y;
    boxColour             = c;
    @(negedge clock);
    loadStartAddress      = 1'b0;
    startingAddressLoaded = 1'b0;
  endtask

  // Waits (bounded) for shapeDone; leaves the bench at the negedge showing it.
  task automatic wait_done(input int bound, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      if (shapeDone) seen = 1'b1;
      else @(negedge clock);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    vec_count++;
    if ({vgaX, vgaY, vgaColour, plot, busy, shapeDone} !== 22'd0) begin
      err_count++;
      $display("FAIL reset_outputs: got %h want 000000", {vgaX, vgaY, vgaColour, plot, busy, shapeDone});
    end
    reset = 1'b0;
  endtask

  task automatic test_basic_box();
    logic [21:0] exp_v;
    logic [21:0] obs_v;
    go(8'd10, 8'd20, 3'd3, 1'b1);
    for (int i = 0; i < 128; i++) begin
      exp_v = {1'b1, 8'(10 + i % 16), 8'(20 + i / 16), 3'd3, 1'b1, 1'b0};
      obs_v = {plot, vgaX, vgaY, vgaColour, busy, shapeDone};
      vec_count++;
      if (obs_v !== exp_v) begin
        err_count++;
        $display("FAIL basic_pixel%0d: got %h want %h", i, obs_v, exp_v);
      end
      @(negedge clock);
    end
    vec_count++;
    if ({plot, busy, shapeDone} !== 3'b001) begin
      err_count++;
      $display("FAIL basic_done: plot/busy/done got %b want 001", {plot, busy, shapeDone});
    end
    @(negedge clock);
    vec_count++;
    if ({plot, busy, shapeDone} !== 3'b000) begin
      err_count++;
      $display("FAIL basic_after_done: plot/busy/done got %b want 000", {plot, busy, shapeDone});
    end
  endtask

  task automatic test_clip();
    int  plots;
    int  x;
    int  y;
    bit  ep;
    plots = 0;
    go(8'd232, 8'd176, 3'd2, 1'b1);
    for (int i = 0; i < 128; i++) begin
      x  = 232 + i % 16;
      y  = 176 + i / 16;
      ep = (x < 240) && (y < 180);
      vec_count++;
      if ({plot, busy, shapeDone} !== {ep, 1'b1, 1'b0}) begin
        err_count++;
        $display("FAIL clip_ctrl%0d: plot/busy/done got %b want %b", i, {plot, busy, shapeDone}, {ep, 1'b1, 1'b0});
      end
      if (ep) begin
        vec_count++;
        if ({vgaX, vgaY, vgaColour} !== {8'(x), 8'(y), 3'd2}) begin
          err_count++;
          $display("FAIL clip_pixel%0d: got %h want %h", i, {vgaX, vgaY, vgaColour}, {8'(x), 8'(y), 3'd2});
        end
      end
      if (plot) plots++;
      @(negedge clock);
    end
    vec_count++;
    if (shapeDone !== 1'b1) begin
      err_count++;
      $display("FAIL clip_done_cycle129: got %b want 1", shapeDone);
    end
    vec_count++;
    if (plots != 32) begin
      err_count++;
      $display("FAIL clip_plot_count: got %0d want 32", plots);
    end
  endtask

  task automatic test_load_and_start();
    bit seen;
    go(8'd0, 8'd0, 3'd5, 1'b1);
    vec_count++;
    if ({plot, vgaX, vgaY, vgaColour} !== {1'b1, 8'd0, 8'd0, 3'd5}) begin
      err_count++;
      $display("FAIL same_cycle_first: got %h want %h", {plot, vgaX, vgaY, vgaColour}, {1'b1, 8'd0, 8'd0, 3'd5});
    end
    @(negedge clock);
    vec_count++;
    if ({plot, vgaX, vgaY, vgaColour} !== {1'b1, 8'd1, 8'd0, 3'd5}) begin
      err_count++;
      $display("FAIL same_cycle_second: got %h want %h", {plot, vgaX, vgaY, vgaColour}, {1'b1, 8'd1, 8'd0, 3'd5});
    end
    wait_done(200, seen);
    vec_count++;
    if (!seen) begin
      err_count++;
      $display("FAIL same_cycle_done: shapeDone got 0 want 1 within 200 cycles");
    end
  endtask

  task automatic test_ignore_during_draw();
    logic [19:0] exp_v;
    int          dones;
    bit          seen;
    dones = 0;
    go(8'd40, 8'd50, 3'd6, 1'b1);
    for (int i = 0; i < 128; i++) begin
      exp_v = {1'b1, 8'(40 + i % 16), 8'(50 + i / 16), 3'd6};
      vec_count++;
      if ({plot, vgaX, vgaY, vgaColour} !== exp_v) begin
        err_count++;
        $display("FAIL ignore_pixel%0d: got %h want %h", i, {plot, vgaX, vgaY, vgaColour}, exp_v);
      end
      if (shapeDone) dones++;
      loadStartAddress      = (i == 10);
      startingAddressLoaded = (i == 10);
      startX                = 8'd100;
      startY                = 8'd100;
      boxColour             = 3'd1;
      @(negedge clock);
    end
    loadStartAddress      = 1'b0;
    startingAddressLoaded = 1'b0;
    for (int j = 0; j < 20; j++) begin
      if (shapeDone) dones++;
      @(negedge clock);
    end
    vec_count++;
    if (dones != 1) begin
      err_count++;
      $display("FAIL ignore_done_count: got %0d want 1", dones);
    end
    go(8'd100, 8'd100, 3'd1, 1'b0);
    vec_count++;
    if ({plot, vgaX, vgaY, vgaColour} !== {1'b1, 8'd40, 8'd50, 3'd6}) begin
      err_count++;
      $display("FAIL ignore_relatch: got %h want %h", {plot, vgaX, vgaY, vgaColour}, {1'b1, 8'd40, 8'd50, 3'd6});
    end
    wait_done(200, seen);
    vec_count++;
    if (!seen) begin
      err_count++;
      $display("FAIL ignore_redraw_done: shapeDone got 0 want 1 within 200 cycles");
    end
  endtask

  task automatic test_async_reset();
    int dones;
    bit seen;
    dones = 0;
    go(8'd60, 8'd70, 3'd4, 1'b1);
    repeat (50) @(negedge clock);
    vec_count++;
    if ({plot, vgaX, vgaY} !== {1'b1, 8'd62, 8'd73}) begin
      err_count++;
      $display("FAIL areset_pixel50: got %h want %h", {plot, vgaX, vgaY}, {1'b1, 8'd62, 8'd73});
    end
    #2 reset = 1'b1;
    #1;
    vec_count++;
    if ({plot, busy, shapeDone, vgaX, vgaY, vgaColour} !== 22'd0) begin
      err_count++;
      $display("FAIL areset_immediate: got %h want 000000", {plot, busy, shapeDone, vgaX, vgaY, vgaColour});
    end
    @(negedge clock);
    reset = 1'b0;
    for (int j = 0; j < 140; j++) begin
      if (shapeDone) dones++;
      @(negedge clock);
    end
    vec_count++;
    if (dones != 0) begin
      err_count++;
      $display("FAIL areset_no_done: got %0d want 0", dones);
    end
    go(8'd77, 8'd77, 3'd7, 1'b0);
    vec_count++;
    if ({plot, busy, vgaX, vgaY, vgaColour} !== {1'b1, 1'b1, 8'd0, 8'd0, 3'd0}) begin
      err_count++;
      $display("FAIL areset_redraw_origin: got %h want %h", {plot, busy, vgaX, vgaY, vgaColour}, {1'b1, 1'b1, 8'd0, 8'd0, 3'd0});
    end
    wait_done(200, seen);
    vec_count++;
    if (!seen) begin
      err_count++;
      $display("FAIL areset_redraw_done: shapeDone got 0 want 1 within 200 cycles");
    end
  endtask

  task automatic test_back_to_back();
    int plots;
    int dones;
    int started;
    int gap;
    int max_gap;
    plots   = 0;
    dones   = 0;
    started = 1;
    gap     = 0;
    max_gap = 0;
    go(8'd5, 8'd5, 3'd7, 1'b1);
    for (int c = 0; c < 600 && dones < 3; c++) begin
      startingAddressLoaded = 1'b0;
      if (plot) begin
        plots++;
        if (gap > max_gap) max_gap = gap;
        gap = 0;
      end else begin
        gap++;
      end
      if (shapeDone) begin
        dones++;
        if (started < 3) begin
          startingAddressLoaded = 1'b1;
          started++;
        end
      end
      @(negedge clock);
    end
    startingAddressLoaded = 1'b0;
    vec_count++;
    if (dones != 3) begin
      err_count++;
      $display("FAIL b2b_done_count: got %0d want 3", dones);
    end
    vec_count++;
    if (plots != 384) begin
      err_count++;
      $display("FAIL b2b_plot_count: got %0d want 384", plots);
    end
    vec_count++;
    if (max_gap != 1) begin
      err_count++;
      $display("FAIL b2b_max_gap: got %0d want 1", max_gap);
    end
    vec_count++;
    if (busy !== 1'b0) begin
      err_count++;
      $display("FAIL b2b_busy_end: got %b want 0", busy);
    end
  endtask

  initial begin
    reset                 = 1'b1;
    loadStartAddress      = 1'b0;
    startingAddressLoaded = 1'b0;
    startX                = 8'd0;
    startY                = 8'd0;
    boxColour             = 3'd0;
    test_reset();
    test_basic_box();
    test_clip();
    test_load_and_start();
    test_ignore_during_draw();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
